// File: rtl/mdu_divider.sv
// rtl/mdu_divider.sv - iterative radix-2 restoring divider with start/ready handshake and cancel
module mdu_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic             cancel_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             ready_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_by_zero_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   prem_q, prem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             a_neg, b_neg;

  // Next-state and datapath: cancel dominates, start accepted only in IDLE/DONE
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    prem_d      = prem_q;
    quo_d       = quo_q;
    dvsr_d      = dvsr_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    a_neg   = signed_i & dividend_i[WIDTH-1];
    b_neg   = signed_i & divisor_i[WIDTH-1];
    // The remainder stays below the divisor, so its top bit is always zero before the shift.
    shifted = {prem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvsr_q};

    if (cancel_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          state_d = S_IDLE;
          if (start_i) begin
            neg_quo_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            quo_d     = a_neg ? -dividend_i : dividend_i;
            dvsr_d    = b_neg ? -divisor_i : divisor_i;
            prem_d    = '0;
            cnt_d     = '0;
            if (divisor_i == '0) begin
              quotient_d  = '1;
              remainder_d = dividend_i;
              dbz_d       = 1'b1;
              state_d     = S_DONE;
            end else begin
              state_d = S_RUN;
            end
          end
        end
        S_RUN: begin
          if (!trial[WIDTH]) begin
            prem_d = trial;
            quo_d  = {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            prem_d = shifted;
            quo_d  = {quo_q[WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
        end
        S_FIX: begin
          quotient_d  = neg_quo_q ? -quo_q : quo_q;
          remainder_d = neg_rem_q ? -prem_q[WIDTH-1:0] : prem_q[WIDTH-1:0];
          dbz_d       = 1'b0;
          state_d     = S_DONE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      prem_q      <= '0;
      quo_q       <= '0;
      dvsr_q      <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      prem_q      <= prem_d;
      quo_q       <= quo_d;
      dvsr_q      <= dvsr_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign busy_o        = (state_q == S_RUN) || (state_q == S_FIX);
  assign ready_o       = (state_q == S_DONE);
  assign quotient_o    = quotient_q;
  assign remainder_o   = remainder_q;
  assign div_by_zero_o = dbz_q;

endmodule
